// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide engine for the EX stage.
// Holds the EX instruction with exc_stall_req while a 32-step shift-add
// multiply or restoring divide runs, then presents HI/LO in DONE.
// Optional build macro MULDIV_FAST_MULT_EN: MULT/MULTU finish in a single
// BUSY cycle using a 64-bit multiplier; divide timing is unaffected.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        pipe_stall,
    input  logic        exception_flush,
    output logic        exc_stall_req,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r;           // mult: {partial, multiplier}; div: {rem, quot}
    logic [31:0] opnd_r;          // mult: |multiplicand|; div: |divisor|
    logic [31:0] dividend_raw_r;  // unsigned-looking copy of src_a for divide-by-zero
    logic        is_div_r;
    logic        neg_main_r;      // product / quotient must be negated
    logic        neg_rem_r;       // remainder must be negated
    logic        div_zero_r;
    logic        res_valid_r;
    logic [31:0] res_hi_r;
    logic [31:0] res_lo_r;

    logic        is_signed_s;
    logic        is_div_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] rem_trial_s;
    logic [32:0] div_diff_s;
    logic [63:0] div_next_s;
    logic [63:0] step_s;
    logic [63:0] prod_s;
    logic        last_s;
    logic [31:0] fin_hi_s;
    logic [31:0] fin_lo_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return (~v) + 64'd1;
    endfunction

    assign is_signed_s = ~op[0];
    assign is_div_s    = op[1];
    assign abs_a_s     = (is_signed_s && src_a[31]) ? neg32(src_a) : src_a;
    assign abs_b_s     = (is_signed_s && src_b[31]) ? neg32(src_b) : src_b;

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        mul_next_s  = {mul_sum_s, acc_r[31:1]};
        rem_trial_s = acc_r[63:31];
        div_diff_s  = rem_trial_s - {1'b0, opnd_r};
        if (!div_diff_s[32]) begin
            div_next_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
        end else begin
            div_next_s = {acc_r[62:0], 1'b0};
        end
    end

    // Select the accumulator update, detect the last step and sign-correct.
    always_comb begin
        step_s = 64'd0;
        last_s = 1'b0;
        prod_s = 64'd0;
        if (is_div_r) begin
            step_s = div_next_s;
            last_s = (cnt_r == 5'd31);
        end else begin
`ifdef MULDIV_FAST_MULT_EN
            step_s = {32'd0, opnd_r} * {32'd0, acc_r[31:0]};
            last_s = 1'b1;
`else
            step_s = mul_next_s;
            last_s = (cnt_r == 5'd31);
`endif
        end
        if (is_div_r) begin
            if (div_zero_r) begin
                fin_lo_s = 32'hFFFF_FFFF;
                fin_hi_s = dividend_raw_r;
            end else begin
                fin_lo_s = neg_main_r ? neg32(step_s[31:0])  : step_s[31:0];
                fin_hi_s = neg_rem_r  ? neg32(step_s[63:32]) : step_s[63:32];
            end
        end else begin
            prod_s   = neg_main_r ? neg64(step_s) : step_s;
            fin_lo_s = prod_s[31:0];
            fin_hi_s = prod_s[63:32];
        end
    end

    // Control FSM with operand latching, iteration and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            cnt_r          <= 5'd0;
            acc_r          <= 64'd0;
            opnd_r         <= 32'd0;
            dividend_raw_r <= 32'd0;
            is_div_r       <= 1'b0;
            neg_main_r     <= 1'b0;
            neg_rem_r      <= 1'b0;
            div_zero_r     <= 1'b0;
            res_valid_r    <= 1'b0;
            res_hi_r       <= 32'd0;
            res_lo_r       <= 32'd0;
        end else if (exception_flush) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r          <= {32'd0, (is_div_s ? abs_a_s : abs_b_s)};
                        opnd_r         <= is_div_s ? abs_b_s : abs_a_s;
                        dividend_raw_r <= src_a;
                        is_div_r       <= is_div_s;
                        neg_main_r     <= is_signed_s & (src_a[31] ^ src_b[31]);
                        neg_rem_r      <= is_signed_s & src_a[31];
                        div_zero_r     <= is_div_s & (src_b == 32'd0);
                        cnt_r          <= 5'd0;
                        state_r        <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    acc_r <= step_s;
                    if (last_s) begin
                        res_hi_r    <= fin_hi_s;
                        res_lo_r    <= fin_lo_s;
                        res_valid_r <= 1'b1;
                        cnt_r       <= 5'd0;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                DONE: begin
                    // start is still high from the same instruction; ignore it
                    if (!pipe_stall) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Flush masks the stall request combinationally in the same cycle.
    assign exc_stall_req = ~exception_flush &
                           (((state_r == IDLE) & start) | (state_r == BUSY));
    assign res_valid     = res_valid_r;
    assign res_hi        = res_hi_r;
    assign res_lo        = res_lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, multi-cycle
// corner sequences (pipe hold, flush, async reset) and random operations
// compared against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        pipe_stall;
    logic        exception_flush;
    logic        exc_stall_req;
    logic        res_valid;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .op              (op),
        .src_a           (src_a),
        .src_b           (src_b),
        .pipe_stall      (pipe_stall),
        .exception_flush (exception_flush),
        .exc_stall_req   (exc_stall_req),
        .res_valid       (res_valid),
        .res_hi          (res_hi),
        .res_lo          (res_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: MIPS-style HI/LO from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_muldiv(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = ua * ub;
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {(ua % ub), 32'd0} | (ua / ub);
            end
        endcase
        return p;
    endfunction

    function automatic int exp_latency(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
        return o[1] ? 33 : 2;
`else
        return 33;
`endif
    endfunction

    // Run one operation; hold DONE with pipe_stall for 'hold' extra cycles.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          output logic [31:0] hi, output logic [31:0] lo);
        int stall_cnt;
        int cyc;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        #1;
        stall_cnt = 0;
        cyc       = 0;
        while (!res_valid && cyc < 100) begin
            if (exc_stall_req) stall_cnt++;
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({name, " valid"}, 64'(res_valid), 64'd1);
        chk({name, " stall_cycles"}, 64'(stall_cnt), 64'(exp_latency(o)));
        chk({name, " no_stall_in_done"}, 64'(exc_stall_req), 64'd0);
        hi = res_hi;
        lo = res_lo;
        if (hold > 0) pipe_stall = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            #1;
            chk({name, " held_valid"}, 64'(res_valid), 64'd1);
            chk({name, " held_result"}, {res_hi, res_lo}, {hi, lo});
            chk({name, " held_no_restart"}, 64'(exc_stall_req), 64'd0);
        end
        pipe_stall = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        #1;
        chk({name, " valid_one_shot"}, 64'(res_valid), 64'd0);
        chk({name, " idle_no_stall"}, 64'(exc_stall_req), 64'd0);
    endtask

    initial begin
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] exp;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          vcount;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{2'b00, 32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4};
        vecs[5] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6] = '{2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        rst             = 1'b1;
        start           = 1'b0;
        op              = 2'b00;
        src_a           = 32'd0;
        src_b           = 32'd0;
        pipe_stall      = 1'b0;
        exception_flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset valid", 64'(res_valid), 64'd0);
        chk("reset result", {res_hi, res_lo}, 64'd0);
        chk("reset stall", 64'(exc_stall_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, hi, lo);
            chk($sformatf("vec%0d result", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
        end

        // DONE held by pipe_stall for 3 cycles: 4 cycles of stable result.
        run_op("hold", 2'b11, 32'd100, 32'd7, 3, hi, lo);
        chk("hold result", {hi, lo}, {32'd2, 32'd14});

        // Flush in BUSY cycle 10 of a MULT.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd5;
        src_b = 32'd6;
        repeat (10) @(negedge clk);
        exception_flush = 1'b1;
        #1;
        chk("flush stall_masked", 64'(exc_stall_req), 64'd0);
        @(negedge clk);
        exception_flush = 1'b0;
        start           = 1'b0;
        #1;
        chk("flush idle_no_stall", 64'(exc_stall_req), 64'd0);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) vcount++;
            @(negedge clk);
            #1;
        end
        chk("flush valid_never", 64'(vcount), 64'd0);
        run_op("post_flush", 2'b00, 32'd3, 32'hFFFF_FFFC, 0, hi, lo);
        chk("post_flush result", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF4});

        // Random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 6 == 1) rb = 32'd0;
            if (i % 6 == 2) rb = 32'($urandom_range(1, 15));
            if (i % 6 == 3) ra = 32'($urandom_range(0, 1000));
            run_op($sformatf("rnd%0d", i), rop, ra, rb, (i % 5 == 0) ? 1 : 0, hi, lo);
            exp = ref_muldiv(rop, ra, rb);
            chk($sformatf("rnd%0d op%0d a=%0h b=%0h", i, rop, ra, rb), {hi, lo}, exp);
        end

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        src_a = 32'd1234;
        src_b = 32'd5;
        repeat (6) @(negedge clk);
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst valid", 64'(res_valid), 64'd0);
        chk("async_rst result", {res_hi, res_lo}, 64'd0);
        chk("async_rst stall", 64'(exc_stall_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 2'b10, 32'hFFFF_FF9C, 32'd7, 0, hi, lo);
        chk("after_rst result", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
